muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the HI/LO multiply-divide resource for the multi-cycle CPU. Accepts one op from the
//  Controller, drives multCalculate and divCalculate from latched operands, waits for completion,
//  then writes the Hi_reg/Lo_reg ports. Handles divide-by-zero, divider timeout and flushes, and
//  stalls MFHI/MFLO until results are committed.
// PARAMETERS
//  DIV_TIMEOUT  40  max DIV_WAIT cycles before abort (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  op_valid      in   1   Controller issues op
//  op_ready      out  1   sequencer idle, op accepted when op_valid&op_ready
//  op_code       in   3   000 MULT,001 MULTU,010 DIV,011 DIVU,100 MTHI,101 MTLO; others ignored
//  rs_data       in   32  rs operand (dividend / multiplicand / MTHI,MTLO source)
//  rt_data       in   32  rt operand (divisor / multiplier)
//  flush         in   1   abort current op, no HI/LO write
//  hilo_read     in   1   Controller executing MFHI/MFLO
//  hilo_stall    out  1   hilo_read & busy
//  busy          out  1   state != IDLE
//  mul_signed    out  1   to multCalculate
//  mul_a, mul_b  out  32  latched rs/rt to multCalculate (one port each)
//  mul_hi,mul_lo in   32  multCalculate result (one port each)
//  div_start     out  1   one-cycle start to divCalculate
//  div_signed    out  1   to divCalculate
//  div_dividend  out  32  latched rs
//  div_divisor   out  32  latched rt
//  div_q, div_r  in   32  quotient / remainder (one port each)
//  div_done      in   1   divider completion
//  hi_we, lo_we  out  1   Hi_reg / Lo_reg write enables (one port each)
//  hi_wdata      out  32  registered HI result
//  lo_wdata      out  32  registered LO result
//  done          out  1   one-cycle pulse, op committed (or div0 completed)
//  err_div0      out  1   one-cycle pulse, DIV/DIVU with rt==0
//  timeout       out  1   one-cycle pulse, divider timeout abort
// BEHAVIOUR
//  - States IDLE, MUL, DIV_START, DIV_WAIT, WRITE. Reset (async): state IDLE, all operand/result
//    regs, counter and every output 0 except op_ready=1. Reset mid-op: op discarded, no HI/LO write.
//  - IDLE: op_ready=1. On accept latch rs/rt, op_code, signed flag (=~op_code[0]) into regs.
//    MULT/MULTU->MUL; DIV/DIVU: rt!=0 ->DIV_START, rt==0 ->IDLE with done+err_div0 pulse (next
//    cycle), div_start never asserted; MTHI/MTLO -> WRITE, result reg = rs. Illegal op_code: stay.
//  - MUL: one cycle; capture mul_hi/mul_lo into result regs at edge -> WRITE.
//  - DIV_START: div_start=1 exactly one cycle; counter cleared -> DIV_WAIT.
//  - DIV_WAIT: counter +1 per cycle. div_done -> capture hi=div_r, lo=div_q -> WRITE. Counter
//    reaching DIV_TIMEOUT with no div_done -> IDLE, timeout pulse, no write. div_done and
//    timeout same cycle: div_done wins. div_done outside DIV_WAIT ignored.
//  - WRITE: one cycle; hi_we/lo_we = (state==WRITE)&~flush&op-selects (MTHI: hi only, MTLO: lo
//    only, mul/div: both); done=1; -> IDLE.
//  - Latency (accept edge = E0): MUL writes at E2; MTHI/MTLO at E1; DIV at div_done edge +1.
//  - flush in any non-IDLE state: combinationally suppresses we, next state IDLE, no done.
//    flush in IDLE has no effect. op_valid while busy ignored; Controller holds it.
//  - Operands stay constant on mul_*/div_* outputs from accept until IDLE.
//  - hilo_stall=1 through WRITE cycle; MFHI/MFLO read after return to IDLE sees new values.
// TESTING
//  1. MULT rs=0xFFFFFFFE, rt=3 -> at E2 hi=0xFFFFFFFF lo=0xFFFFFFFA, hi_we=lo_we=1 one cycle, done 1 cycle.
//  2. DIVU rs=100 rt=7, divider model done after 33 cycles -> div_start 1 cycle, lo=14 hi=2 written.
//  3. DIV rt=0 -> err_div0+done pulses, div_start/hi_we/lo_we stay 0, op_ready=1 next cycle.
//  4. DIV, div_done never asserted, DIV_TIMEOUT=40 -> timeout pulse after 40 DIV_WAIT cycles, no write.
//  5. flush in DIV_WAIT and in WRITE; reset low mid-MUL -> IDLE, no we; op_valid during busy ignored.
//  6. MTHI rs=0x12345678 -> hi_we 1 cycle, lo_we 0; hilo_read while busy -> hilo_stall=1, 0 in IDLE.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply-divide sequencer: accepts one op when idle, commits HI/LO one cycle after the result is available.
// Latency: MTHI/MTLO 1 cycle, MUL 2 cycles, DIV div_done + 1; while busy op_ready=0 and op_valid is ignored.
module muldiv_sequencer #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    input  logic        hilo_read,
    output logic        hilo_stall,
    output logic        busy,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_done,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        done,
    output logic        err_div0,
    output logic        timeout
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int CW = (DIV_TIMEOUT < 2) ? 1 : $clog2(DIV_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_START,
        S_DIV_WAIT,
        S_WRITE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [2:0]    op_q;
    logic          sgn_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          err_q;
    logic          tmo_q;

    logic          accept;
    logic          div0;
    logic          tmo;
    logic          wr_done;
    logic          sel_hi;
    logic          sel_lo;

    // MTLO leaves HI untouched and MTHI leaves LO untouched; mul/div write both.
    assign sel_hi = (op_q != OP_MTLO);
    assign sel_lo = (op_q != OP_MTHI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        div0      = 1'b0;
        tmo       = 1'b0;
        wr_done   = 1'b0;
        op_ready  = 1'b0;
        div_start = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            accept    = 1'b1;
                            state_nxt = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            accept = 1'b1;
                            if (rt_data == 32'd0) begin
                                div0 = 1'b1;
                            end else begin
                                state_nxt = S_DIV_START;
                            end
                        end
                        OP_MTHI, OP_MTLO: begin
                            accept    = 1'b1;
                            state_nxt = S_WRITE;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                state_nxt = S_WRITE;
            end
            S_DIV_START: begin
                div_start = 1'b1;
                state_nxt = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                // A completion landing on the last allowed cycle still commits.
                if (div_done) begin
                    state_nxt = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                hi_we     = sel_hi;
                lo_we     = sel_lo;
                wr_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (flush && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            hi_we     = 1'b0;
            lo_we     = 1'b0;
            wr_done   = 1'b0;
            tmo       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            sgn_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            done_q <= div0;
            err_q  <= div0;
            tmo_q  <= tmo;
            if (accept) begin
                a_q   <= rs_data;
                b_q   <= rt_data;
                op_q  <= op_code;
                sgn_q <= ~op_code[0];
                if (op_code == OP_MTHI) begin
                    hi_q <= rs_data;
                end
                if (op_code == OP_MTLO) begin
                    lo_q <= rs_data;
                end
            end
            if (state == S_MUL) begin
                hi_q <= mul_hi;
                lo_q <= mul_lo;
            end
            if (state == S_DIV_START) begin
                cnt_q <= '0;
            end
            if (state == S_DIV_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (div_done) begin
                    hi_q <= div_r;
                    lo_q <= div_q;
                end
            end
        end
    end

    assign busy         = (state != S_IDLE);
    assign hilo_stall   = hilo_read & busy;
    assign mul_signed   = sgn_q;
    assign mul_a        = a_q;
    assign mul_b        = b_q;
    assign div_signed   = sgn_q;
    assign div_dividend = a_q;
    assign div_divisor  = b_q;
    assign hi_wdata     = hi_q;
    assign lo_wdata     = lo_q;
    assign done         = done_q | wr_done;
    assign err_div0     = err_q;
    assign timeout      = tmo_q;

endmodule
